// File: rtl/quiz_buzzer_n.sv
`default_nettype none
// ============================================================================
// Module   : quiz_buzzer_n
// Brief    : N-player quiz buzzer. Edge-detected presses, first single press
//            arms a timed answer window; wrongly-judged players are locked out
//            until the host clears the question.
// Options  : BUZZER_TIE_PRIO_EN - when defined, a simultaneous press is
//            resolved in favour of the lowest-index pressing player instead
//            of being rejected (tie_p pulses in both builds).
// Revision : 1.0 - initial release
// ============================================================================
module quiz_buzzer_n #(
  parameter int N_PLAYERS = 4,
  parameter int CNT_W     = 16,
  parameter int TIMEOUT   = 1000,
  localparam int WIN_W    = (N_PLAYERS > 2) ? $clog2(N_PLAYERS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_PLAYERS-1:0] sw,
  input  logic                 clr,
  input  logic                 judge_ok,
  input  logic                 judge_ng,
  output logic [N_PLAYERS-1:0] led,
  output logic [WIN_W-1:0]     winner,
  output logic                 busy,
  output logic                 correct,
  output logic [N_PLAYERS-1:0] lockout,
  output logic                 all_out,
  output logic                 tie_p,
  output logic                 timeout_p
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACT  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // A zero TIMEOUT disables the window, so the timer is simply parked at 0.
  localparam logic             TMO_EN   = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] TMR_LOAD = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);
  localparam logic [N_PLAYERS-1:0] ONE  = N_PLAYERS'(1);

`ifdef BUZZER_TIE_PRIO_EN
  localparam logic TIE_PRIO = 1'b1;
`else
  localparam logic TIE_PRIO = 1'b0;
`endif

  logic [1:0]           state_q,   state_d;
  logic [N_PLAYERS-1:0] sw_q;
  logic [N_PLAYERS-1:0] led_q,     led_d;
  logic [WIN_W-1:0]     winner_q,  winner_d;
  logic [N_PLAYERS-1:0] lockout_q, lockout_d;
  logic [CNT_W-1:0]     timer_q,   timer_d;
  logic                 busy_q, correct_q, all_out_q;
  logic                 tie_q,  tie_d;
  logic                 tmo_q,  tmo_d;

  logic [N_PLAYERS-1:0] rise_w;
  logic [4:0]           rise_cnt_w;
  logic [WIN_W-1:0]     first_w;

  // Rising edges from eligible players, their count and the lowest index.
  always_comb begin
    rise_w     = sw & ~sw_q & ~lockout_q;
    rise_cnt_w = '0;
    first_w    = '0;
    for (int i = N_PLAYERS - 1; i >= 0; i--) begin
      rise_cnt_w = rise_cnt_w + 5'(rise_w[i]);
      if (rise_w[i]) first_w = WIN_W'(i);
    end
  end

  // Question state machine; clr overrides everything including pulses.
  always_comb begin
    state_d   = state_q;
    led_d     = led_q;
    winner_d  = winner_q;
    lockout_d = lockout_q;
    timer_d   = timer_q;
    tie_d     = 1'b0;
    tmo_d     = 1'b0;
    if (clr) begin
      state_d   = ST_IDLE;
      led_d     = '0;
      winner_d  = '0;
      lockout_d = '0;
      timer_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          tie_d = (rise_cnt_w >= 5'd2);
          if ((rise_cnt_w == 5'd1) || (tie_d && TIE_PRIO)) begin
            state_d  = ST_ACT;
            winner_d = first_w;
            led_d    = ONE << first_w;
            timer_d  = TMR_LOAD;
          end
        end
        ST_ACT: begin
          if (judge_ok) begin
            state_d = ST_DONE;
          end else if (judge_ng || (TMO_EN && (timer_q == '0))) begin
            // led_q is one-hot on the current winner, so it doubles as the lockout mask.
            lockout_d = lockout_q | led_q;
            tmo_d     = ~judge_ng;
            state_d   = ST_IDLE;
            led_d     = '0;
            winner_d  = '0;
            timer_d   = '0;
          end else if (TMO_EN) begin
            timer_d = timer_q - 1'b1;
          end
        end
        ST_DONE: begin
          state_d = ST_DONE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State and registered outputs; sw_q resets high so held buttons never fire.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      sw_q      <= '1;
      led_q     <= '0;
      winner_q  <= '0;
      lockout_q <= '0;
      timer_q   <= '0;
      busy_q    <= 1'b0;
      correct_q <= 1'b0;
      all_out_q <= 1'b0;
      tie_q     <= 1'b0;
      tmo_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sw_q      <= sw;
      led_q     <= led_d;
      winner_q  <= winner_d;
      lockout_q <= lockout_d;
      timer_q   <= timer_d;
      busy_q    <= (state_d != ST_IDLE);
      correct_q <= (state_d == ST_DONE);
      all_out_q <= &lockout_d;
      tie_q     <= tie_d;
      tmo_q     <= tmo_d;
    end
  end

  assign led       = led_q;
  assign winner    = winner_q;
  assign busy      = busy_q;
  assign correct   = correct_q;
  assign lockout   = lockout_q;
  assign all_out   = all_out_q;
  assign tie_p     = tie_q;
  assign timeout_p = tmo_q;

endmodule
`default_nettype wire

// File: tb/tb_quiz_buzzer_n.sv
`default_nettype none
// ============================================================================
// Module   : tb_quiz_buzzer_n
// Brief    : Directed self-checking bench for quiz_buzzer_n (N=4, TIMEOUT=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_quiz_buzzer_n;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] sw;
  logic       clr, judge_ok, judge_ng;
  logic [3:0] led, lockout;
  logic [1:0] winner;
  logic       busy, correct, all_out, tie_p, timeout_p;

  int checks = 0;
  int errors = 0;

  quiz_buzzer_n #(.N_PLAYERS(4), .CNT_W(16), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .sw(sw), .clr(clr),
    .judge_ok(judge_ok), .judge_ng(judge_ng),
    .led(led), .winner(winner), .busy(busy), .correct(correct),
    .lockout(lockout), .all_out(all_out), .tie_p(tie_p), .timeout_p(timeout_p)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; sw = 4'b0000; clr = 1'b0; judge_ok = 1'b0; judge_ng = 1'b0;
    tick(2);
    chk("rst_led", 32'(led), 32'h0);
    chk("rst_winner", 32'(winner), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_correct", 32'(correct), 32'h0);
    chk("rst_lockout", 32'(lockout), 32'h0);
    chk("rst_all_out", 32'(all_out), 32'h0);
    chk("rst_tie", 32'(tie_p), 32'h0);
    chk("rst_tmo", 32'(timeout_p), 32'h0);
    rst = 1'b0;
    tick(1);

    // Single press, judged correct, then cleared.
    sw = 4'b0100; tick(1);
    chk("p2_led", 32'(led), 32'h4);
    chk("p2_winner", 32'(winner), 32'h2);
    chk("p2_busy", 32'(busy), 32'h1);
    chk("p2_correct_pre", 32'(correct), 32'h0);
    sw = 4'b0000; judge_ok = 1'b1; tick(1);
    chk("ok_correct", 32'(correct), 32'h1);
    chk("ok_led_hold", 32'(led), 32'h4);
    judge_ok = 1'b0; clr = 1'b1; tick(1);
    chk("clr_led", 32'(led), 32'h0);
    chk("clr_busy", 32'(busy), 32'h0);
    chk("clr_correct", 32'(correct), 32'h0);
    chk("clr_winner", 32'(winner), 32'h0);
    clr = 1'b0;

    // Wrong answer locks player 1 out; re-press ignored; player 3 can win.
    sw = 4'b0010; tick(1);
    chk("p1_led", 32'(led), 32'h2);
    sw = 4'b0000; judge_ng = 1'b1; tick(1);
    chk("ng_busy", 32'(busy), 32'h0);
    chk("ng_lockout", 32'(lockout), 32'h2);
    judge_ng = 1'b0; sw = 4'b0010; tick(1);
    chk("locked_repress", 32'(busy), 32'h0);
    sw = 4'b0000; tick(1);
    sw = 4'b1000; tick(1);
    chk("p3_led", 32'(led), 32'h8);
    chk("p3_winner", 32'(winner), 32'h3);
    sw = 4'b0000; clr = 1'b1; tick(1);
    chk("clr2_lockout", 32'(lockout), 32'h0);
    clr = 1'b0;

    // Timeout: ACT entered at edge k, timeout_p after edge k+8 only.
    sw = 4'b0001; tick(1);
    chk("to_busy", 32'(busy), 32'h1);
    sw = 4'b0000; tick(7);
    chk("to_busy_k7", 32'(busy), 32'h1);
    chk("to_tmo_k7", 32'(timeout_p), 32'h0);
    tick(1);
    chk("to_tmo_k8", 32'(timeout_p), 32'h1);
    chk("to_busy_k8", 32'(busy), 32'h0);
    chk("to_lockout", 32'(lockout), 32'h1);
    tick(1);
    chk("to_pulse_end", 32'(timeout_p), 32'h0);
    clr = 1'b1; tick(1);
    clr = 1'b0;

    // Simultaneous press.
    sw = 4'b0110; tick(1);
    chk("tie_pulse", 32'(tie_p), 32'h1);
`ifdef BUZZER_TIE_PRIO_EN
    chk("tie_led", 32'(led), 32'h2);
    chk("tie_winner", 32'(winner), 32'h1);
    chk("tie_busy", 32'(busy), 32'h1);
`else
    chk("tie_led", 32'(led), 32'h0);
    chk("tie_busy", 32'(busy), 32'h0);
`endif
    tick(1);
    chk("tie_pulse_end", 32'(tie_p), 32'h0);
    sw = 4'b0000; clr = 1'b1; tick(1);
    clr = 1'b0;

    // Lock out every player.
    for (int p = 0; p < 4; p++) begin
      sw = 4'(1 << p); tick(1);
      chk("all_led", 32'(led), 32'(1 << p));
      sw = 4'b0000; judge_ng = 1'b1; tick(1);
      judge_ng = 1'b0;
    end
    chk("all_lockout", 32'(lockout), 32'hF);
    chk("all_out_set", 32'(all_out), 32'h1);
    sw = 4'b1111; tick(1);
    chk("all_ignored", 32'(busy), 32'h0);
    sw = 4'b0000; clr = 1'b1; tick(1);
    chk("all_clr_lockout", 32'(lockout), 32'h0);
    chk("all_clr_all_out", 32'(all_out), 32'h0);
    clr = 1'b0;

    // judge_ok on the cycle the timer expires wins over the timeout.
    sw = 4'b0100; tick(1);
    sw = 4'b0000; tick(7);
    judge_ok = 1'b1; tick(1);
    chk("okto_correct", 32'(correct), 32'h1);
    chk("okto_tmo", 32'(timeout_p), 32'h0);
    chk("okto_lockout", 32'(lockout), 32'h0);
    judge_ok = 1'b0; clr = 1'b1; tick(1);
    clr = 1'b0;

    // Reset mid-ACT, then a button held through reset must not fire.
    sw = 4'b0001; tick(1);
    chk("mid_busy", 32'(busy), 32'h1);
    rst = 1'b1; tick(1);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    chk("mid_rst_led", 32'(led), 32'h0);
    rst = 1'b0; tick(2);
    chk("held_no_act", 32'(busy), 32'h0);
    sw = 4'b0000; tick(1);
    sw = 4'b0001; tick(1);
    chk("repress_act", 32'(busy), 32'h1);
    chk("repress_winner", 32'(winner), 32'h0);
    chk("repress_led", 32'(led), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/quiz_buzzer_n.md
# quiz_buzzer_n

Parametrised N-player quiz buzzer. Button presses are edge-detected, and the first single press arms an answer window with a timeout. Players the host judges wrong are locked out for the rest of the question. Sits between debounced player buttons and the host/LED panel, and replaces the fixed two-player buzzer.

## Interface
- N_PLAYERS, 4: number of player buttons/LEDs; legal range 2..16.
- CNT_W, 16: answer-timer width.
- TIMEOUT, 1000: answer window in clk cycles; must be < 2^CNT_W; 0 disables the timeout.
- WIN_W (localparam): $clog2(N_PLAYERS), minimum 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- sw  in  N_PLAYERS  player buttons, already debounced and synchronous to clk.
- clr  in  1  host clear / next question.
- judge_ok  in  1  host: current answer correct.
- judge_ng  in  1  host: current answer wrong.
- led  out  N_PLAYERS  one-hot current winner.
- winner  out  WIN_W  index of current winner.
- busy  out  1  state != IDLE.
- correct  out  1  state == DONE.
- lockout  out  N_PLAYERS  players barred for this question.
- all_out  out  1  lockout is all ones.
- tie_p  out  1  one-cycle pulse: simultaneous press rejected.
- timeout_p  out  1  one-cycle pulse: answer window expired.

## Operation
- Edge detect: sw_q <= sw every cycle; rise = sw & ~sw_q & ~lockout. sw_q resets to all ones, so buttons held through reset never fire.
- States: IDLE, ACT, DONE. Encoding is free.
- IDLE:
  - popcount(rise)==1 -> ACT; winner/led latch that player; timer loads TIMEOUT-1.
  - popcount(rise)>=2 -> stay IDLE, tie_p (see Configuration).
  - rise==0 -> stay.
- ACT: timer decrements each cycle. Priority order is clr > judge_ok > judge_ng > timeout.
  - judge_ok -> DONE.
  - judge_ng -> lockout[winner] set, -> IDLE.
  - Timer==0 with no judge and TIMEOUT!=0 -> lockout[winner] set, timeout_p, -> IDLE.
  - Presses are ignored in ACT and DONE. sw_q still tracks sw there, so a held button does not fire on return to IDLE.
- DONE: led/winner hold until clr. judge_* are ignored.
- clr (any state) -> IDLE; lockout, timer, led and winner cleared. Pulses are suppressed that cycle.
- Once all_out=1, no player can win until clr.
- judge_ok/judge_ng in IDLE or DONE are ignored. If both are asserted in ACT, judge_ok wins.

## Timing
- All outputs are registered.
- Reset values: led=0, winner=0, busy=0, correct=0, lockout=0, all_out=0, tie_p=0, timeout_p=0; state IDLE; timer 0; sw_q all ones.
- Press latency: sw low at edge k-1 and high at edge k -> led/busy valid after edge k (1 cycle).
- Timeout: entering ACT at edge k with no judge -> timeout_p high for the cycle after edge k+TIMEOUT, and state is IDLE in that same cycle.
- A judge_ng sampled at edge m -> IDLE and lockout bit visible after edge m. The earliest new winner can be accepted at edge m+1.
- Pulses last exactly one cycle.
- rst mid-question aborts to reset values, including lockout.

## Configuration
- BUZZER_TIE_PRIO_EN defined: on a simultaneous press (popcount>=2), the lowest-index pressing player wins and enters ACT. tie_p is still pulsed for host logging.
- BUZZER_TIE_PRIO_EN undefined: on a simultaneous press, the block stays in IDLE and pulses tie_p, and no winner is latched. Those buttons must be released and re-pressed to try again.

## Test plan
- N=4, TIMEOUT=8: sw=0100 rises -> after 1 cycle led=0100, winner=2, busy=1; judge_ok -> correct=1; clr -> all outputs 0.
- Press player 1, then judge_ng -> lockout=0010, IDLE. Re-press player 1 -> ignored. Press player 3 -> led=1000.
- Press player 0 with no judge -> timeout_p exactly 8 cycles after ACT entry, lockout=0001, busy=0.
- sw=0110 in one cycle. Macro off -> tie_p, stays IDLE, led=0. Macro on -> tie_p, led=0010, winner=1.
- Lock out all 4 players via judge_ng -> all_out=1 and further presses are ignored. clr -> lockout=0, all_out=0.
- sw=0001 held across rst -> no ACT after reset. Also: rst asserted mid-ACT -> reset values on the next cycle. Also: judge_ok and timer==0 in the same cycle -> DONE, no timeout_p.
